// File: rtl/icache_pkg.sv
// Shared bus widths, level constants and FSM encoding for the instruction cache.
package icache_pkg;

  localparam int ADDR_W         = 32;
  localparam int INST_W         = 32;
  localparam int ICACHE_INDEX_W = 7;
  localparam int ICACHE_TAG_W   = ADDR_W - 2 - ICACHE_INDEX_W;

  typedef logic [ADDR_W-1:0]         AddrBus;
  typedef logic [INST_W-1:0]         InstBus;
  typedef logic [ICACHE_INDEX_W-1:0] ICacheIndexBus;
  typedef logic [ICACHE_TAG_W-1:0]   ICacheTagBus;

  localparam logic   Enable  = 1'b1;
  localparam logic   Disable = 1'b0;
  localparam logic   Valid   = 1'b1;
  localparam logic   Invalid = 1'b0;
  localparam InstBus Null    = '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } icacheState_t;

  // Clears the byte offset so the memory controller always sees a word address.
  function automatic AddrBus alignWord(input AddrBus addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one fill port, one async lookup port.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = ADDR_W - 2 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_fillEn,
  input  logic [INDEX_W-1:0] i_fillIndex,
  input  logic [TAG_W-1:0]   i_fillTag,
  input  InstBus             i_fillData,
  input  logic [INDEX_W-1:0] i_lookupIndex,
  input  logic [TAG_W-1:0]   i_lookupTag,
  output logic               o_hit,
  output InstBus             o_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  InstBus           r_data [LINES];

  // Valid bits are the only storage cleared by reset; a fill marks its line valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_fillEn) begin
      r_valid[i_fillIndex] <= Valid;
    end
  end

  // Tag and data are written on fill only and are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (i_fillEn) begin
      r_tag[i_fillIndex]  <= i_fillTag;
      r_data[i_fillIndex] <= i_fillData;
    end
  end

  assign o_hit  = r_valid[i_lookupIndex] && (r_tag[i_lookupIndex] == i_lookupTag);
  assign o_data = r_data[i_lookupIndex];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: single-cycle hits, single-word refill on a miss,
// flush aborts an outstanding miss without touching the stored lines.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rdy,
  input  logic   clear,
  input  logic   fetch_en_i,
  input  AddrBus pc_i,
  output logic   inst_valid_o,
  output InstBus inst_o,
  output logic   mem_en_o,
  output AddrBus mem_addr_o,
  input  logic   mem_valid_i,
  input  InstBus mem_inst_i
);

  icacheState_t r_state;
  icacheState_t w_nextState;
  AddrBus       r_missAddr;
  logic         r_instValid;
  InstBus       r_inst;

  AddrBus             w_pcAligned;
  logic [INDEX_W-1:0] w_lookupIndex;
  logic [TAG_W-1:0]   w_lookupTag;
  logic [INDEX_W-1:0] w_fillIndex;
  logic [TAG_W-1:0]   w_fillTag;
  logic               w_hit;
  InstBus             w_lineData;
  logic               w_fillEn;
  logic               w_acceptMiss;
  logic               w_acceptHit;

  assign w_pcAligned   = alignWord(pc_i);
  assign w_lookupIndex = w_pcAligned[INDEX_W+1:2];
  assign w_lookupTag   = w_pcAligned[ADDR_W-1:INDEX_W+2];
  assign w_fillIndex   = r_missAddr[INDEX_W+1:2];
  assign w_fillTag     = r_missAddr[ADDR_W-1:INDEX_W+2];

  // A returning word is stored even when a flush lands on the same edge, since it is
  // still the correct data for the latched miss address.
  assign w_fillEn = !rst && rdy && (r_state == MISS) && mem_valid_i;

  assign w_acceptHit  = rdy && !clear && (r_state == IDLE) && fetch_en_i && w_hit;
  assign w_acceptMiss = rdy && !clear && (r_state == IDLE) && fetch_en_i && !w_hit;

  icache_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .i_fillEn     (w_fillEn),
    .i_fillIndex  (w_fillIndex),
    .i_fillTag    (w_fillTag),
    .i_fillData   (mem_inst_i),
    .i_lookupIndex(w_lookupIndex),
    .i_lookupTag  (w_lookupTag),
    .o_hit        (w_hit),
    .o_data       (w_lineData)
  );

  // State register; everything holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: flush wins over everything, a miss waits for the single memory response.
  always_comb begin
    w_nextState = r_state;
    if (rdy) begin
      if (clear) begin
        w_nextState = IDLE;
      end else begin
        case (r_state)
          IDLE:    if (w_acceptMiss) w_nextState = MISS;
          MISS:    if (mem_valid_i)  w_nextState = IDLE;
          default: w_nextState = IDLE;
        endcase
      end
    end
  end

  // Miss address is captured only when a miss is accepted, so it stays stable for the refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_missAddr <= '0;
    end else if (w_acceptMiss) begin
      r_missAddr <= w_pcAligned;
    end
  end

  // Output registers: a pulse for a hit or a completed refill; the word is held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instValid <= Invalid;
      r_inst      <= Null;
    end else if (!rdy || clear) begin
      r_instValid <= Invalid;
    end else if (w_acceptHit) begin
      r_instValid <= Valid;
      r_inst      <= w_lineData;
    end else if ((r_state == MISS) && mem_valid_i) begin
      r_instValid <= Valid;
      r_inst      <= mem_inst_i;
    end else begin
      r_instValid <= Invalid;
    end
  end

  assign inst_valid_o = r_instValid;
  assign inst_o       = r_inst;

  // The request drops in the response cycle so the controller does not launch a second read.
  assign mem_en_o   = !rst && (r_state == MISS) && !mem_valid_i;
  assign mem_addr_o = rst ? AddrBus'(0) : r_missAddr;

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for the instruction cache with a few hand-written sequences.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        fetchEn;
  logic [31:0] pc;
  logic        instValid;
  logic [31:0] inst;
  logic        memEn;
  logic [31:0] memAddr;
  logic        memValid;
  logic [31:0] memInst;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] W0    = 32'h0010_0093;
  localparam logic [31:0] W4    = 32'hAAAA_0004;
  localparam logic [31:0] W204  = 32'hBBBB_0204;
  localparam logic [31:0] W10   = 32'hCCCC_0010;
  localparam logic [31:0] LATE  = 32'hDEAD_0010;
  localparam logic [31:0] W8    = 32'h0020_8113;
  localparam logic [31:0] WC    = 32'h1111_0C0C;

  typedef struct {
    logic        fe;
    logic [31:0] pc;
    logic        clr;
    logic        rd;
    logic        mv;
    logic [31:0] mi;
    logic        expMemEn;
    logic [31:0] expMemAddr;
    logic        expValid;
    logic        chkInst;
    logic [31:0] expInst;
  } vec_t;

  vec_t vecs[$];

  icache dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .clear       (clear),
    .fetch_en_i  (fetchEn),
    .pc_i        (pc),
    .inst_valid_o(instValid),
    .inst_o      (inst),
    .mem_en_o    (memEn),
    .mem_addr_o  (memAddr),
    .mem_valid_i (memValid),
    .mem_inst_i  (memInst)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the bench stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(input logic fe, input logic [31:0] p, input logic clr,
                                 input logic rd, input logic mv, input logic [31:0] mi,
                                 input logic eEn, input logic [31:0] eAddr, input logic eV,
                                 input logic cI, input logic [31:0] eI);
    vec_t v;
    v.fe = fe; v.pc = p; v.clr = clr; v.rd = rd; v.mv = mv; v.mi = mi;
    v.expMemEn = eEn; v.expMemAddr = eAddr; v.expValid = eV; v.chkInst = cI; v.expInst = eI;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic fe, input logic [31:0] p, input logic clr,
                               input logic rd, input logic mv, input logic [31:0] mi);
    fetchEn  = fe;
    pc       = p;
    clear    = clr;
    rdy      = rd;
    memValid = mv;
    memInst  = mi;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  initial begin
    int pulses;
    int waitCycles;

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;

    // Cold miss at 0x0, then a warm hit on the same address.
    addVec(1, 32'h000, 0, 1, 0, 0,    0, 32'h000, 0, 1, 32'h0);
    addVec(1, 32'h000, 0, 1, 0, 0,    1, 32'h000, 0, 0, 0);
    addVec(1, 32'h000, 0, 1, 0, 0,    1, 32'h000, 0, 0, 0);
    addVec(1, 32'h000, 0, 1, 1, W0,   0, 32'h000, 1, 1, W0);
    addVec(0, 32'h000, 0, 1, 0, 0,    0, 32'h000, 0, 1, W0);
    addVec(1, 32'h000, 0, 1, 0, 0,    0, 32'h000, 1, 1, W0);
    addVec(0, 32'h000, 0, 1, 0, 0,    0, 32'h000, 0, 1, W0);
    // Conflict on index 1: 0x004 and 0x204 evict each other.
    addVec(1, 32'h004, 0, 1, 0, 0,    0, 32'h000, 0, 0, 0);
    addVec(1, 32'h004, 0, 1, 0, 0,    1, 32'h004, 0, 0, 0);
    addVec(1, 32'h004, 0, 1, 1, W4,   0, 32'h004, 1, 1, W4);
    addVec(1, 32'h204, 0, 1, 0, 0,    0, 32'h004, 0, 1, W4);
    addVec(1, 32'h204, 0, 1, 0, 0,    1, 32'h204, 0, 0, 0);
    addVec(1, 32'h204, 0, 1, 1, W204, 0, 32'h204, 1, 1, W204);
    addVec(1, 32'h004, 0, 1, 0, 0,    0, 32'h204, 0, 0, 0);
    addVec(1, 32'h004, 0, 1, 0, 0,    1, 32'h004, 0, 0, 0);
    addVec(1, 32'h004, 0, 1, 1, W4,   0, 32'h004, 1, 1, W4);
    addVec(0, 32'h004, 0, 1, 0, 0,    0, 32'h004, 0, 0, 0);
    // Flush two cycles into a miss, then a late response while idle.
    addVec(1, 32'h010, 0, 1, 0, 0,    0, 32'h004, 0, 0, 0);
    addVec(1, 32'h010, 0, 1, 0, 0,    1, 32'h010, 0, 0, 0);
    addVec(1, 32'h010, 1, 1, 0, 0,    1, 32'h010, 0, 0, 0);
    addVec(0, 32'h010, 0, 1, 0, 0,    0, 32'h010, 0, 0, 0);
    addVec(0, 32'h010, 0, 1, 1, LATE, 0, 32'h010, 0, 1, W4);
    addVec(1, 32'h010, 0, 1, 0, 0,    0, 32'h010, 0, 0, 0);
    addVec(1, 32'h010, 0, 1, 0, 0,    1, 32'h010, 0, 0, 0);
    addVec(1, 32'h010, 0, 1, 1, W10,  0, 32'h010, 1, 1, W10);
    addVec(1, 32'h010, 0, 1, 0, 0,    0, 32'h010, 1, 1, W10);
    // Stall for three cycles with a hit pending; the request is served once rdy returns.
    addVec(1, 32'h000, 0, 0, 0, 0,    0, 32'h010, 0, 1, W10);
    addVec(1, 32'h000, 0, 0, 0, 0,    0, 32'h010, 0, 1, W10);
    addVec(1, 32'h000, 0, 0, 0, 0,    0, 32'h010, 0, 1, W10);
    addVec(1, 32'h000, 0, 1, 0, 0,    0, 32'h010, 1, 1, W0);
    // Warm 0x008 with a zero-latency response, then stream three hits.
    addVec(1, 32'h008, 0, 1, 0, 0,    0, 32'h010, 0, 0, 0);
    addVec(1, 32'h008, 0, 1, 1, W8,   0, 32'h008, 1, 1, W8);
    addVec(1, 32'h000, 0, 1, 0, 0,    0, 32'h008, 1, 1, W0);
    addVec(1, 32'h004, 0, 1, 0, 0,    0, 32'h008, 1, 1, W4);
    addVec(1, 32'h008, 0, 1, 0, 0,    0, 32'h008, 1, 1, W8);
    addVec(0, 32'h008, 0, 1, 0, 0,    0, 32'h008, 0, 0, 0);
    // Flush coinciding with the response still fills the line but gives no pulse.
    addVec(1, 32'h00C, 0, 1, 0, 0,    0, 32'h008, 0, 0, 0);
    addVec(1, 32'h00C, 0, 1, 0, 0,    1, 32'h00C, 0, 0, 0);
    addVec(1, 32'h00C, 1, 1, 1, WC,   0, 32'h00C, 0, 1, W8);
    addVec(1, 32'h00C, 0, 1, 0, 0,    0, 32'h00C, 1, 1, WC);
    // Flush beats a same-edge fetch: no miss is latched.
    addVec(1, 32'h014, 1, 1, 0, 0,    0, 32'h00C, 0, 1, WC);
    addVec(0, 32'h014, 0, 1, 0, 0,    0, 32'h00C, 0, 0, 0);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.instValid", {31'b0, instValid}, 32'h0);
    checkOutput("reset.inst",      inst,               32'h0);
    checkOutput("reset.memEn",     {31'b0, memEn},     32'h0);
    checkOutput("reset.memAddr",   memAddr,            32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].fe, vecs[i].pc, vecs[i].clr, vecs[i].rd, vecs[i].mv, vecs[i].mi);
      @(negedge clk);
      checkOutput($sformatf("v%0d.memEn", i),   {31'b0, memEn}, {31'b0, vecs[i].expMemEn});
      checkOutput($sformatf("v%0d.memAddr", i), memAddr,        vecs[i].expMemAddr);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.instValid", i), {31'b0, instValid}, {31'b0, vecs[i].expValid});
      if (vecs[i].chkInst) begin
        checkOutput($sformatf("v%0d.inst", i), inst, vecs[i].expInst);
      end
    end

    // Reset in the middle of a miss: request lines drop at once and the lines are invalidated.
    applyStimulus(1'b1, 32'h018, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h018, 1'b0, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midReset.memEn",   {31'b0, memEn}, 32'h0);
    checkOutput("midReset.memAddr", memAddr,        32'h0);
    @(posedge clk);
    #1;
    checkOutput("midReset.instValid", {31'b0, instValid}, 32'h0);
    checkOutput("midReset.inst",      inst,               32'h0);
    rst = 1'b0;

    // Previously warm 0x000 now misses; serve it after a few cycles and count the pulses.
    applyStimulus(1'b1, 32'h000, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("afterReset.instValid", {31'b0, instValid}, 32'h0);
    fetchEn = 1'b0;
    waitCycles = 0;
    while (!memEn && waitCycles < 20) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("afterReset.memEn",   {31'b0, memEn}, 32'h1);
    checkOutput("afterReset.memAddr", memAddr,        32'h0);
    repeat (3) @(posedge clk);
    #1;
    memValid = 1'b1;
    memInst  = W0;
    pulses   = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      memValid = 1'b0;
      memInst  = 32'h0;
      if (instValid) pulses++;
    end
    checkOutput("afterReset.pulses", pulses, 32'd1);
    checkOutput("afterReset.inst",   inst,   W0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
